// File: rtl/graph_sram_loader.sv
// Packs a stream of host words into memory lines and writes them at consecutive, wrapping addresses.
// Output latency: a line is written in the cycle after its last word; throughput is one line per 5 cycles; the host waits whenever in_ready is low.
module graph_sram_loader #(
    parameter int ADDR_W = 13,
    parameter int LINE_W = 128,
    parameter int IN_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_lines,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_ready,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [LINE_W-1:0] WriteBus,
    output logic              busy,
    output logic              done
);
    localparam int LANES  = LINE_W / IN_W;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [LANE_W-1:0] lane;
    logic [ADDR_W:0]   line_cnt;
    logic [ADDR_W:0]   num_q;
    logic [ADDR_W:0]   next_cnt;
    logic [ADDR_W-1:0] base_q;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] packed_line;
    logic              hs;
    logic              last_lane;

    assign in_ready  = (state == S_LOAD);
    assign busy      = (state == S_LOAD) || (state == S_WRITE);
    assign hs        = in_ready & in_valid;
    assign last_lane = (lane == LANE_W'(LANES - 1));
    assign next_cnt  = line_cnt + 1'b1;

    // The final word goes straight to the output register, so no extra cycle is spent buffering it.
    always_comb begin
        packed_line = line_buf;
        packed_line[lane*IN_W +: IN_W] = in_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            lane         <= '0;
            line_cnt     <= '0;
            num_q        <= '0;
            base_q       <= '0;
            line_buf     <= '0;
            WriteEnable  <= 1'b0;
            WriteAddress <= '0;
            WriteBus     <= '0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        num_q    <= num_lines;
                        line_cnt <= '0;
                        lane     <= '0;
                        if (num_lines == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        line_buf <= packed_line;
                        lane     <= lane + 1'b1;
                        if (last_lane) begin
                            WriteEnable  <= 1'b1;
                            WriteAddress <= base_q + line_cnt[ADDR_W-1:0];
                            WriteBus     <= packed_line;
                            state        <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    WriteEnable <= 1'b0;
                    line_cnt    <= next_cnt;
                    lane        <= '0;
                    if (next_cnt == num_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_graph_sram_loader.sv
// Directed bench for graph_sram_loader: drives host words and start requests, then checks captured writes, done timing and reset behaviour.
module tb_graph_sram_loader;
    logic         clock;
    logic         reset;
    logic         start;
    logic [12:0]  base_addr;
    logic [13:0]  num_lines;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         WriteEnable;
    logic [12:0]  WriteAddress;
    logic [127:0] WriteBus;
    logic         busy;
    logic         done;

    graph_sram_loader dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .num_lines(num_lines), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
        .WriteBus(WriteBus), .busy(busy), .done(done)
    );

    int vectors;
    int miscompares;
    int cyc;
    int start_cyc;
    int done_cyc;
    int done_cnt;
    logic [31:0]  words [64];
    logic [12:0]  got_addr [$];
    logic [127:0] got_data [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (WriteEnable) begin
            got_addr.push_back(WriteAddress);
            got_data.push_back(WriteBus);
            check("ready_low_in_write", in_ready, 1'b0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
    endtask

    task automatic fill(input logic [7:0] seed);
        for (int i = 0; i < 64; i++)
            words[i] = {seed, 8'(i), ~8'(i), 8'(i * 3)};
    endtask

    // Leaves the bench at the negedge of the first LOAD cycle.
    task automatic do_start(input logic [12:0] b, input logic [13:0] n);
        @(negedge clock);
        start = 1'b1; base_addr = b; num_lines = n;
        start_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int n, input bit stall);
        int idx;
        int guard;
        idx = first;
        guard = 0;
        while (idx < first + n && guard < 2000) begin
            if (in_ready && !(stall && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b1;
                in_data  = words[idx];
                idx++;
            end else begin
                in_valid = 1'b0;
                in_data  = 32'hdead_beef;
            end
            @(negedge clock);
            guard++;
        end
        in_valid = 1'b0;
        check("feed_in_time", guard < 2000, 1'b1);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done_cnt == 0 && g < 200) begin
            @(negedge clock);
            g++;
        end
        check("done_seen", done_cnt != 0, 1'b1);
        repeat (3) @(negedge clock);
        check("done_once", done_cnt, 1);
    endtask

    task automatic check_writes(input string tag, input logic [12:0] b, input int n);
        logic [12:0] a;
        check({tag, "_count"}, got_addr.size(), n);
        if (got_addr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                a = b + 13'(i);
                check({tag, "_addr"}, got_addr[i], a);
                check({tag, "_data"}, got_data[i],
                      {words[4*i+3], words[4*i+2], words[4*i+1], words[4*i]});
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; done_cnt = 0;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", WriteEnable, 0);
        check("rst_addr", WriteAddress, 0);
        check("rst_bus", WriteBus, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // single line, back-to-back words
        clear_log();
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        words[2] = 32'h33333333; words[3] = 32'h44444444;
        do_start(13'd5, 14'd1);
        check("single_busy", busy, 1'b1);
        feed(0, 4, 1'b0);
        wait_done();
        check_writes("single", 13'd5, 1);
        if (got_data.size() == 1)
            check("single_line", got_data[0], 128'h44444444_33333333_22222222_11111111);
        check("single_latency", done_cyc - start_cyc + 1, 7);

        // three lines with random stalls
        clear_log();
        fill(8'hA1);
        do_start(13'd100, 14'd3);
        feed(0, 12, 1'b1);
        wait_done();
        check_writes("stall", 13'd100, 3);

        // address wrap
        clear_log();
        fill(8'hB2);
        do_start(13'd8190, 14'd4);
        feed(0, 16, 1'b1);
        wait_done();
        check_writes("wrap", 13'd8190, 4);
        if (got_addr.size() == 4) begin
            check("wrap_third", got_addr[2], 13'd0);
            check("wrap_fourth", got_addr[3], 13'd1);
        end

        // zero length
        clear_log();
        do_start(13'd7, 14'd0);
        check("zero_ready", in_ready, 1'b0);
        check("zero_done_now", done, 1'b1);
        wait_done();
        check("zero_writes", got_addr.size(), 0);
        check("zero_latency", done_cyc - start_cyc + 1, 2);

        // reset after six words: only the first line lands
        clear_log();
        fill(8'hC3);
        do_start(13'd0, 14'd2);
        feed(0, 6, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_we", WriteEnable, 0);
        check("mid_rst_addr", WriteAddress, 0);
        check("mid_rst_bus", WriteBus, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check_writes("mid_rst", 13'd0, 1);
        @(negedge clock);
        reset = 1'b0;
        clear_log();
        fill(8'hD4);
        do_start(13'd50, 14'd1);
        feed(0, 4, 1'b0);
        wait_done();
        check_writes("after_rst", 13'd50, 1);

        // start during LOAD must be ignored
        clear_log();
        fill(8'hE5);
        do_start(13'd20, 14'd2);
        feed(0, 2, 1'b0);
        check("ign_busy", busy, 1'b1);
        start = 1'b1; base_addr = 13'd9; num_lines = 14'd1;
        @(negedge clock);
        start = 1'b0;
        feed(2, 6, 1'b0);
        wait_done();
        check_writes("ignore", 13'd20, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/graph_sram_loader.md
# graph_sram_loader

Write-side front end for the 8K x 128-bit graph memory. Accepts a host stream of 32-bit words with a valid/ready handshake, packs each group of four words into one 128-bit line, and drives the memory write port at consecutive addresses starting from a programmed base. It is the counterpart to the graph datapath, which only reads the memory through its two read ports. A start/done handshake frames each load.

## Interface
Parameters:
- ADDR_W, 13, memory address width (8192 lines)
- LINE_W, 128, memory word width
- IN_W, 32, host word width; LINE_W/IN_W = 4 lanes per line

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle load request; sampled only in IDLE
- base_addr  in  ADDR_W  first line address; latched on accepted start
- num_lines  in  ADDR_W+1  line count, 0..8192; latched on accepted start
- in_valid  in  1  host word valid
- in_data  in  IN_W  host word
- in_ready  out  1  loader accepts a word this cycle
- WriteEnable  out  1  memory write strobe, one cycle per line
- WriteAddress  out  ADDR_W  memory line address
- WriteBus  out  LINE_W  memory write data
- busy  out  1  load in progress (states LOAD, WRITE)
- done  out  1  single-cycle pulse when the load completes

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready=0, busy=0. On start=1, latch base_addr and num_lines, clear line_cnt and lane.
  - num_lines==0 -> DONE.
  - Otherwise -> LOAD.
- LOAD: in_ready=1. Each handshake (in_valid & in_ready) stores in_data into lane `lane`:
  - lane 0 -> bits [31:0], lane 1 -> [63:32], lane 2 -> [95:64], lane 3 -> [127:96].
  - After each handshake, lane increments. The handshake on lane 3 -> WRITE.
  - in_valid=0 stalls indefinitely with no state change.
- WRITE: in_ready=0.
  - WriteEnable=1, WriteAddress=(base+line_cnt) mod 8192, WriteBus=packed line.
  - line_cnt increments. If the new line_cnt==num_lines -> DONE, else -> LOAD with lane=0.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- start while not in IDLE is ignored, including in DONE.
- The address wraps modulo 2^ADDR_W. Example: base 8190 with 4 lines writes 8190, 8191, 0, 1.
- There is no partial-line flush. Words accepted after the final line are impossible because in_ready is 0 outside LOAD.
- Reset (asynchronous, any state) behaviour:
  - State returns to IDLE.
  - WriteEnable, in_ready, busy and done go to 0.
  - WriteAddress, WriteBus, lane and line_cnt go to 0.
  - A partially packed line is discarded and nothing is written.

## Timing
- Reset values of all outputs are 0.
- WriteEnable, WriteAddress, WriteBus and done are registered. They are stable for the whole cycle, so the memory captures the write at the clock edge that ends the WRITE cycle.
- in_ready and busy are decoded from the state register only, with no combinational path from in_valid.
- Latency from start to the first LOAD cycle is 1 cycle.
- The WRITE cycle immediately follows the cycle of the 4th handshake.
- Throughput is one line per 5 cycles at best: 4 LOAD cycles plus 1 WRITE.
- done is asserted in the cycle after the last WRITE. An N-line load with in_valid held high takes 5N+2 cycles from start to done inclusive.
- WriteAddress and WriteBus hold their last values outside WRITE. They are don't-care when WriteEnable=0, but they must not be X after reset.
- Simultaneous start and reset: reset wins.

## Test plan
- Single line: base=5, num_lines=1, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back.
  - One WriteEnable pulse with addr 5 and data 0x44444444_33333333_22222222_11111111.
  - done 1 cycle later. Total 7 cycles from start to done.
- Multi-line with stalls: base=100, num_lines=3, with in_valid toggled randomly.
  - Exactly 3 writes at addresses 100, 101, 102 with the correct packed data.
  - in_ready low during each WRITE. done once.
- Wrap-around: base=8190, num_lines=4 -> writes at 8190, 8191, 0, 1 in that order.
- Zero length: num_lines=0 -> no WriteEnable and no in_ready; done pulses 2 cycles after start.
- Reset mid-load: base=0, num_lines=2; assert reset after 6 words are accepted.
  - Exactly one write (addr 0) has occurred. All outputs are 0 immediately.
  - A subsequent start with base=50, num_lines=1 writes at addr 50 with fresh lane ordering.
- start ignored while busy: pulse start with base=9 during LOAD of a base=20, num_lines=2 load -> writes at 20 and 21 only.
